frame_sequencer: RTL
====================

# frame_sequencer

Per-frame scheduler for the shared sprite-draw datapath. On each frame tick it erases every active entity at its last-drawn position, grants one entity-state update, then redraws every active entity. Entities are visited in ship, asteroid, shot order, one at a time, through a start/done handshake. It sits between the entity registers and the single drawer that feeds the VGA adapter's plot port.

## Interface
- ENTITY_SIZE, 34, entity word width. Fields: [33] active, [32:26] attributes, [25:16] y, [15:6] x, [5:0] direction.
- MAX_SHIPS, 1, ship slots.
- MAX_ASTEROIDS, 3, asteroid slots.
- MAX_SHOTS, 3, shot slots.

Ports (N = MAX_SHIPS+MAX_ASTEROIDS+MAX_SHOTS):
- clk  in  1  system clock (50 MHz). One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse, synchronous to clk; requests a frame.
- ship  in  ENTITY_SIZE*MAX_SHIPS  packed ship words, slot 0 in LSBs.
- asteroids  in  ENTITY_SIZE*MAX_ASTEROIDS  packed asteroid words.
- shots  in  ENTITY_SIZE*MAX_SHOTS  packed shot words.
- draw_start  out  1  one-cycle request to the drawer.
- draw_entity  out  ENTITY_SIZE  entity word for the drawer.
- draw_kind  out  2  entity kind: 0 ship, 1 asteroid, 2 shot (3 unused).
- draw_erase  out  1  1 = draw in background colour.
- draw_done  in  1  one-cycle completion pulse from the drawer.
- update_en  out  1  one-cycle pulse; entity owners may step state on this cycle only.
- busy  out  1  high whenever state is not IDLE.
- overrun_cnt  out  8  saturating count of frame ticks dropped while busy.

## Operation
- Global slot index s runs 0..N-1 (ships, then asteroids, then shots); counter width $clog2(N).
- Shadow file: N registers hold each slot's word as last issued for draw. All shadows reset to 0, i.e. inactive.
- States:
  - IDLE: if frame_tick, set s=0 and go to ERASE_ISSUE.
  - ERASE_ISSUE: if shadow[s][33]=0, advance s. Otherwise drive draw_start=1 with draw_entity=shadow[s] and draw_erase=1, then go to ERASE_WAIT.
  - ERASE_WAIT: on draw_done, advance s and go to ERASE_ISSUE.
  - After slot N-1 of the erase phase, go to UPDATE.
  - UPDATE: update_en=1 for one cycle, then go to SETTLE.
  - SETTLE: one idle cycle so the updated entity words are visible. Set s=0 and go to DRAW_ISSUE.
  - DRAW_ISSUE: sample the live word for slot s. If bit[33]=0, write it into shadow[s] (clearing it) and advance s. Otherwise write it into shadow[s], drive draw_start=1 with draw_erase=0, and go to DRAW_WAIT.
  - DRAW_WAIT: on draw_done, advance s.
  - After slot N-1 of the draw phase, go to IDLE.
- draw_entity, draw_kind and draw_erase are registered. They are loaded in the ISSUE cycle and held unchanged until the cycle draw_done is accepted, even if the live inputs change meanwhile.
- A frame_tick seen in any state other than IDLE is dropped: overrun_cnt increments, saturating at 255. overrun_cnt clears only on reset.
- draw_done outside a WAIT state is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, s=0, all shadows 0. Reset is effective immediately, including mid-handshake; the drawer must tolerate an abandoned request.
- frame_tick sampled at edge T: busy=1 from T+1.
- Each inactive slot costs 1 cycle. Each active slot costs 1 ISSUE cycle plus the WAIT cycles.
- draw_done is accepted as early as the cycle after draw_start.
- All-inactive frame: busy for exactly 2N+2 cycles, with update_en in cycle N+1 of busy.
- A frame_tick in the same cycle the FSM returns to IDLE counts as an overrun. A tick on the following cycle starts a new frame.

## Test plan
- All 7 slots inactive, single tick: busy=1 for 16 cycles; update_en high only on busy cycle 8; draw_start never asserted.
- Only ship active (x=5, y=7, dir=1), drawer answers done 3 cycles after start:
  - frame 1: no erase; one draw with draw_erase=0, draw_kind=0, draw_entity equal to the ship word.
  - ship moves to x=6, frame 2: erase issued with x=5, then draw issued with x=6.
- Ship, asteroids[1] and shots[0] active: draw_start sequence in each phase is kinds 0, 1, 2 at s=0, 2, 4; erase phase precedes update_en, which precedes the draw phase.
- Input word changed during DRAW_WAIT: draw_entity holds the sampled value until done.
- Tick every 10 cycles with done delayed 50 cycles: each dropped tick increments overrun_cnt; after 300 drops it reads 255.
- reset_n low during ERASE_WAIT: outputs and overrun_cnt go to 0 immediately; the next frame performs no erase (shadows cleared).

Source files
------------

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//   Per-frame scheduler for the shared sprite-draw datapath. On every frame
//   tick it erases each entity that was drawn active last frame (using the
//   word it drew, not the current one), grants a single entity-state update,
//   then samples and redraws every active entity. Slots are visited in ship,
//   asteroid, shot order through a start/done handshake with one drawer.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   frame_tick   one-cycle frame request
//   ship         packed ship words, slot 0 in LSBs
//   asteroids    packed asteroid words
//   shots        packed shot words
//   draw_start   one-cycle request to the drawer (registered)
//   draw_entity  entity word for the drawer (registered, held until done)
//   draw_kind    0 ship, 1 asteroid, 2 shot (registered)
//   draw_erase   1 = background colour (registered)
//   draw_done    one-cycle completion pulse from the drawer
//   update_en    one-cycle window in which entity owners may step state
//   busy         high whenever the sequencer is not idle
//   overrun_cnt  saturating count of frame ticks dropped while busy
//
// States
//   IDLE        | waiting for frame_tick
//   ERASE_ISSUE | test shadow[s]; skip or request an erase of it
//   ERASE_WAIT  | erase in flight, wait for draw_done
//   UPDATE      | update_en high for one cycle
//   SETTLE      | let the updated entity words propagate
//   DRAW_ISSUE  | sample live word into shadow[s]; skip or request a draw
//   DRAW_WAIT   | draw in flight, wait for draw_done
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int ENTITY_SIZE   = 34,
  parameter int MAX_SHIPS     = 1,
  parameter int MAX_ASTEROIDS = 3,
  parameter int MAX_SHOTS     = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               frame_tick,
  input  logic [ENTITY_SIZE*MAX_SHIPS-1:0]     ship,
  input  logic [ENTITY_SIZE*MAX_ASTEROIDS-1:0] asteroids,
  input  logic [ENTITY_SIZE*MAX_SHOTS-1:0]     shots,
  output logic                               draw_start,
  output logic [ENTITY_SIZE-1:0]             draw_entity,
  output logic [1:0]                         draw_kind,
  output logic                               draw_erase,
  input  logic                               draw_done,
  output logic                               update_en,
  output logic                               busy,
  output logic [7:0]                         overrun_cnt
);

  localparam int N   = MAX_SHIPS + MAX_ASTEROIDS + MAX_SHOTS;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;
  localparam int ACT = ENTITY_SIZE - 1;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_ISSUE,
    ERASE_WAIT,
    UPDATE,
    SETTLE,
    DRAW_ISSUE,
    DRAW_WAIT
  } state_t;

  state_t                   state, state_nxt;
  logic [SW-1:0]            slot, slot_nxt;
  logic                     last_slot;
  logic                     issue, issue_erase, shadow_we;
  logic [N*ENTITY_SIZE-1:0] live_all;
  logic [N*ENTITY_SIZE-1:0] shadow_all;
  logic [ENTITY_SIZE-1:0]   cur_live, cur_shadow;
  logic [1:0]               cur_kind;

  // Global slot order: ships, then asteroids, then shots.
  assign live_all   = {shots, asteroids, ship};
  assign cur_live   = live_all[int'(slot)*ENTITY_SIZE +: ENTITY_SIZE];
  assign cur_shadow = shadow_all[int'(slot)*ENTITY_SIZE +: ENTITY_SIZE];
  assign last_slot  = (slot == SW'(N - 1));

  always_comb begin
    cur_kind = 2'd2;
    if (int'(slot) < MAX_SHIPS) begin
      cur_kind = 2'd0;
    end else if (int'(slot) < MAX_SHIPS + MAX_ASTEROIDS) begin
      cur_kind = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot;
    issue       = 1'b0;
    issue_erase = 1'b0;
    shadow_we   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          slot_nxt  = '0;
          state_nxt = ERASE_ISSUE;
        end
      end
      ERASE_ISSUE: begin
        if (!cur_shadow[ACT]) begin
          if (last_slot) state_nxt = UPDATE;
          else           slot_nxt  = slot + SW'(1);
        end else begin
          issue       = 1'b1;
          issue_erase = 1'b1;
          state_nxt   = ERASE_WAIT;
        end
      end
      ERASE_WAIT: begin
        if (draw_done) begin
          if (last_slot) begin
            state_nxt = UPDATE;
          end else begin
            slot_nxt  = slot + SW'(1);
            state_nxt = ERASE_ISSUE;
          end
        end
      end
      UPDATE: begin
        state_nxt = SETTLE;
      end
      SETTLE: begin
        slot_nxt  = '0;
        state_nxt = DRAW_ISSUE;
      end
      DRAW_ISSUE: begin
        // Inactive words are recorded too, so next frame skips their erase.
        shadow_we = 1'b1;
        if (!cur_live[ACT]) begin
          if (last_slot) begin
            slot_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            slot_nxt  = slot + SW'(1);
          end
        end else begin
          issue     = 1'b1;
          state_nxt = DRAW_WAIT;
        end
      end
      DRAW_WAIT: begin
        if (draw_done) begin
          if (last_slot) begin
            slot_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            slot_nxt  = slot + SW'(1);
            state_nxt = DRAW_ISSUE;
          end
        end
      end
      default: begin
        slot_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_all <= '0;
    end else if (shadow_we) begin
      shadow_all[int'(slot)*ENTITY_SIZE +: ENTITY_SIZE] <= cur_live;
    end
  end

  // Request fields are captured at issue and left untouched until the next
  // issue, so the drawer sees a stable word for the whole handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_start  <= 1'b0;
      draw_entity <= '0;
      draw_kind   <= 2'd0;
      draw_erase  <= 1'b0;
    end else begin
      draw_start <= issue;
      if (issue) begin
        draw_entity <= issue_erase ? cur_shadow : cur_live;
        draw_kind   <= cur_kind;
        draw_erase  <= issue_erase;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= 8'd0;
    end else if (frame_tick && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign update_en = (state == UPDATE);
  assign busy      = (state != IDLE);

endmodule
